// File: rtl/spi_word_responder.sv
// spi_word_responder: SPI mode-0 responder with a 2**AW x 16-bit word memory (READ 0x03 / WRITE 0x02).
// Define SPI_RESP_STATUS_EN to add the RDSR (0x05) sticky status byte.
module spi_word_responder #(
    parameter int AW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          csb_i,
    input  logic          sclk_i,
    input  logic          mo_i,
    output logic          mi_o,
    output logic          busy_o,
    input  logic [AW-1:0] loc_addr_i,
    output logic [15:0]   loc_data_o
);
    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RDATA, WDATA,
`ifdef SPI_RESP_STATUS_EN
        STATUS,
`endif
        IGNORE
    } state_t;
    logic [SYNC_STAGES-1:0] csb_q, sclk_q, mo_q;
    logic                   csb_d, sclk_d, csb, sclk, mo, rise, fall, csb_fall;
    state_t                 state, state_n;
    logic [3:0]             cnt, cnt_n;
    logic [14:0]            rx, rx_n;
    logic [15:0]            tx, tx_n, wd;
    logic [AW-1:0]          addr, addr_n, addr_inc;
    logic                   rd, rd_n, mi_n, we;
    logic [15:0]            mem [2**AW];
    assign csb      = csb_q[SYNC_STAGES-1];
    assign sclk     = sclk_q[SYNC_STAGES-1];
    assign mo       = mo_q[SYNC_STAGES-1];
    assign rise     = sclk & ~sclk_d;
    assign fall     = ~sclk & sclk_d;
    assign csb_fall = csb_d & ~csb;
    assign wd       = {rx, mo};
    assign addr_inc = addr + AW'(1);
    assign busy_o   = state != IDLE;
`ifdef SPI_RESP_STATUS_EN
    logic wr_f, wrap_f;
    always_ff @(posedge clk) begin
        if (!resetb) begin
            wr_f   <= 1'b0;
            wrap_f <= 1'b0;
        end else begin
            if (we) wr_f <= 1'b1;
            if ((&addr) && addr_n == '0 && (state == RDATA || state == WDATA)) wrap_f <= 1'b1;
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (!resetb) begin
            csb_q  <= '1;
            sclk_q <= '0;
            mo_q   <= '0;
            csb_d  <= 1'b1;
            sclk_d <= 1'b0;
        end else begin
            csb_q  <= {csb_q[SYNC_STAGES-2:0], csb_i};
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            mo_q   <= {mo_q[SYNC_STAGES-2:0], mo_i};
            csb_d  <= csb;
            sclk_d <= sclk;
        end
    end
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= IDLE;
            cnt   <= '0;
            rx    <= '0;
            tx    <= '0;
            addr  <= '0;
            rd    <= 1'b0;
            mi_o  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rx    <= rx_n;
            tx    <= tx_n;
            addr  <= addr_n;
            rd    <= rd_n;
            mi_o  <= mi_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rx_n    = rx;
        tx_n    = tx;
        addr_n  = addr;
        rd_n    = rd;
        mi_n    = 1'b0;
        we      = 1'b0;
        if (csb) begin
            state_n = IDLE;
            cnt_n   = '0;
            rx_n    = '0;
        end else begin
            case (state)
                IDLE: state_n = csb_fall ? CMD : IDLE;
                CMD: if (rise) begin
                    rx_n  = wd[14:0];
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n   = '0;
                        rd_n    = wd[7:0] == 8'h03;
                        state_n = (wd[7:0] == 8'h03 || wd[7:0] == 8'h02) ? ADDR : IGNORE;
`ifdef SPI_RESP_STATUS_EN
                        if (wd[7:0] == 8'h05) begin
                            state_n = STATUS;
                            tx_n    = {6'b0, wrap_f, wr_f, 8'h00};
                        end
`endif
                    end
                end
                ADDR: if (rise) begin
                    rx_n  = wd[14:0];
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        cnt_n   = '0;
                        addr_n  = wd[AW-1:0];
                        tx_n    = mem[wd[AW-1:0]];
                        state_n = rd ? RDATA : WDATA;
                    end
                end
                // bit 0 leaves on the 16th fall, which also preloads the next word
                RDATA: begin
                    mi_n = mi_o;
                    if (fall) begin
                        mi_n  = tx[15];
                        tx_n  = {tx[14:0], 1'b0};
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            cnt_n  = '0;
                            addr_n = addr_inc;
                            tx_n   = mem[addr_inc];
                        end
                    end
                end
                WDATA: if (rise) begin
                    rx_n  = wd[14:0];
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        cnt_n  = '0;
                        we     = 1'b1;
                        addr_n = addr_inc;
                    end
                end
`ifdef SPI_RESP_STATUS_EN
                STATUS: begin
                    mi_n = mi_o;
                    if (fall) begin
                        mi_n  = tx[15];
                        tx_n  = {tx[14:0], 1'b0};
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n = '0;
                            tx_n  = {6'b0, wrap_f, wr_f, 8'h00};
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (we && resetb) mem[addr] <= wd;
    end
    always_ff @(posedge clk) begin
        if (!resetb) loc_data_o <= '0;
        else loc_data_o <= mem[loc_addr_i];
    end
endmodule

// File: tb/tb_spi_word_responder.sv
// tb_spi_word_responder: directed SPI master transactions against a word-level memory model.
module tb_spi_word_responder;
    logic        clk = 1'b0, resetb = 1'b0, csb_i = 1'b1, sclk_i = 1'b0, mo_i = 1'b0;
    logic        mi_o, busy_o;
    logic [7:0]  loc_addr_i = 8'h00, loc_q = 8'h00;
    logic [15:0] loc_data_o, got = 16'h0000;
    logic [15:0] mdl [256];
    bit          mdl_v [256];
    bit          chk_en = 1'b0, mi_quiet = 1'b0;
    logic [15:0] rdq [$];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    spi_word_responder dut (
        .clk(clk), .resetb(resetb), .csb_i(csb_i), .sclk_i(sclk_i), .mo_i(mo_i),
        .mi_o(mi_o), .busy_o(busy_o), .loc_addr_i(loc_addr_i), .loc_data_o(loc_data_o)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) loc_q <= loc_addr_i;

    always @(negedge clk) begin
        if (mi_quiet) chk("mi_quiet", {15'b0, mi_o}, 16'h0000);
        if (chk_en) begin
            chk("idle_busy", {15'b0, busy_o}, 16'h0000);
            chk("idle_mi", {15'b0, mi_o}, 16'h0000);
            if (mdl_v[loc_q]) chk("loc_model", loc_data_o, mdl[loc_q]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start();
        chk_en = 1'b0;
        csb_i  = 1'b0;
        cyc(4);
    endtask

    task automatic stop();
        cyc(4);
        csb_i = 1'b1;
        cyc(6);
    endtask

    task automatic send(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mo_i = v[i];
            cyc(4);
            sclk_i = 1'b1;
            got = {got[14:0], mi_o};
            cyc(4);
            sclk_i = 1'b0;
        end
    endtask

    task automatic wr(input logic [15:0] a, input int n, input logic [15:0] w0, input logic [15:0] w1,
                      input int pbits, input logic [15:0] pv);
        logic [7:0]  ix;
        logic [15:0] w;
        start();
        send(16'h0002, 8);
        send(a, 16);
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : w1;
            send(w, 16);
            ix = a[7:0] + 8'(k);
            mdl[ix] = w;
            mdl_v[ix] = 1'b1;
        end
        if (pbits > 0) send(pv, pbits);
        stop();
    endtask

    task automatic rd(input logic [15:0] a, input int n);
        logic [7:0] ix;
        rdq.delete();
        start();
        send(16'h0003, 8);
        send(a, 16);
        for (int k = 0; k < n; k++) begin
            send(16'h0000, 16);
            rdq.push_back(got);
            ix = a[7:0] + 8'(k);
            if (mdl_v[ix]) chk("rd_model", got, mdl[ix]);
        end
        stop();
    endtask

    task automatic scan(input logic [7:0] a);
        loc_addr_i = a;
        chk_en = 1'b1;
        cyc(3);
        chk_en = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cyc(4);
        chk("rst_busy", {15'b0, busy_o}, 16'h0000);
        chk("rst_mi", {15'b0, mi_o}, 16'h0000);
        chk("rst_loc", loc_data_o, 16'h0000);
        resetb = 1'b1;
        cyc(4);
        // write/readback
        wr(16'h0010, 2, 16'hBEEF, 16'hCAFE, 0, 16'h0000);
        rd(16'h0010, 2);
        chk("t1_w0", rdq[0], 16'hBEEF);
        chk("t1_w1", rdq[1], 16'hCAFE);
        loc_addr_i = 8'h11;
        cyc(2);
        chk("t1_loc", loc_data_o, 16'hCAFE);
        scan(8'h10);
        scan(8'h11);
        // address wrap in one write stream
        wr(16'h00FF, 2, 16'h1234, 16'h5678, 0, 16'h0000);
        rd(16'h00FF, 2);
        chk("t2_w0", rdq[0], 16'h1234);
        chk("t2_w1", rdq[1], 16'h5678);
        scan(8'hFF);
        scan(8'h00);
`ifdef SPI_RESP_STATUS_EN
        start();
        send(16'h0005, 8);
        send(16'h0000, 8);
        chk("t2_rdsr", {8'h00, got[7:0]}, 16'h0003);
        send(16'h0000, 8);
        chk("t2_rdsr_rep", {8'h00, got[7:0]}, 16'h0003);
        stop();
`else
        mi_quiet = 1'b1;
        start();
        send(16'h0005, 8);
        send(16'h0000, 16);
        stop();
        mi_quiet = 1'b0;
`endif
        // partial write is dropped
        wr(16'h0020, 1, 16'h1111, 16'h0000, 0, 16'h0000);
        wr(16'h0020, 0, 16'h0000, 16'h0000, 9, 16'h01FF);
        scan(8'h20);
        chk("t3_loc", loc_data_o, 16'h1111);
        chk("t3_busy", {15'b0, busy_o}, 16'h0000);
        // unknown command
        mi_quiet = 1'b1;
        start();
        send(16'h009F, 8);
        send(16'h0000, 16);
        chk("t4_busy", {15'b0, busy_o}, 16'h0001);
        stop();
        mi_quiet = 1'b0;
        scan(8'h10);
        scan(8'h20);
        rd(16'h0010, 1);
        chk("t4_rd", rdq[0], 16'hBEEF);
        // reset in the middle of a read word
        start();
        send(16'h0003, 8);
        send(16'h0010, 16);
        send(16'h0000, 6);
        mo_i = 1'b0;
        cyc(4);
        sclk_i = 1'b1;
        cyc(3);
        chk("t5_pre_mi", {15'b0, mi_o}, 16'h0001);
        resetb = 1'b0;
        cyc(1);
        chk("t5_mi", {15'b0, mi_o}, 16'h0000);
        chk("t5_busy", {15'b0, busy_o}, 16'h0000);
        chk("t5_loc", loc_data_o, 16'h0000);
        cyc(3);
        sclk_i = 1'b0;
        csb_i = 1'b1;
        cyc(2);
        resetb = 1'b1;
        cyc(6);
        rd(16'h0010, 1);
        chk("t5_rd", rdq[0], 16'hBEEF);
        // upper address bits ignored, csb aborts
        rd(16'h8010, 2);
        chk("t6_w0", rdq[0], 16'hBEEF);
        chk("t6_w1", rdq[1], 16'hCAFE);
        start();
        send(16'h0003, 8);
        send(16'h0000, 5);
        stop();
        rd(16'h0011, 1);
        chk("t6_abort_rd", rdq[0], 16'hCAFE);
        start();
        send(16'h0002, 8);
        send(16'h0010, 16);
        send(16'hFFFF, 7);
        stop();
        rd(16'h0010, 1);
        chk("t6_abort_wr", rdq[0], 16'hBEEF);
        scan(8'h10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
